// File: rtl/prog_bitstream_shifter.sv
// Drives the fabric serial programming port: MSB-first byte serializer with a divided
// prog clock, serial readback capture into bytes, and a timed prog-reset generator.
module prog_bitstream_shifter #(
  parameter int unsigned CLK_DIV          = 4,
  parameter int unsigned RST_HALF_PERIODS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       cfg_reset,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       prog_clk,
  output logic       prog_rst,
  output logic       prog_en,
  output logic       prog_dout,
  input  logic       prog_din,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST      = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_HALF_PERIODS * CLK_DIV - 1);

  logic [2:0]  state;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [15:0] rst_cnt;
  logic [7:0]  tx_q;
  logic [7:0]  rx_q;
  logic        last_q;
  logic        div_done;
  logic        accept;

  assign div_done = (div_cnt == DIV_LAST);
  assign accept   = s_valid && s_ready && (state == ST_IDLE || state == ST_GAP);

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rst_cnt   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      last_q    <= 1'b0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      prog_clk  <= 1'b0;
      prog_rst  <= 1'b0;
      prog_en   <= 1'b0;
      prog_dout <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        // First bit goes out together with prog_en; the rest wait in tx_q.
        state     <= ST_SHIFT_LO;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        tx_q      <= {s_data[6:0], 1'b0};
        last_q    <= s_last;
        s_ready   <= 1'b0;
        busy      <= 1'b1;
        prog_en   <= 1'b1;
        prog_clk  <= 1'b0;
        prog_dout <= s_data[7];
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_reset) begin
              state    <= ST_RST;
              rst_cnt  <= '0;
              prog_rst <= 1'b1;
              s_ready  <= 1'b0;
              busy     <= 1'b1;
            end else begin
              s_ready <= 1'b1;
            end
          end
          ST_RST: begin
            if (rst_cnt == RST_LAST) begin
              state    <= ST_IDLE;
              prog_rst <= 1'b0;
              s_ready  <= 1'b1;
              busy     <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + 16'd1;
            end
          end
          ST_SHIFT_LO: begin
            if (div_done) begin
              state    <= ST_SHIFT_HI;
              div_cnt  <= '0;
              prog_clk <= 1'b1;
              rx_q     <= {rx_q[6:0], prog_din};
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          ST_SHIFT_HI: begin
            if (div_done) begin
              div_cnt  <= '0;
              prog_clk <= 1'b0;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) begin
                state     <= ST_SHIFT_LO;
                prog_dout <= tx_q[7];
                tx_q      <= {tx_q[6:0], 1'b0};
              end else begin
                m_valid <= 1'b1;
                m_data  <= rx_q;
                s_ready <= 1'b1;
                if (last_q) begin
                  state   <= ST_IDLE;
                  prog_en <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end else begin
                  state <= ST_GAP;
                end
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          ST_GAP: begin
            s_ready <= 1'b1;
          end
          default: begin
            state   <= ST_IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_bitstream_shifter.sv
// Scoreboard bench: a fabric model checks serialized bits and supplies readback bytes,
// a monitor pops expected readback/timing on every m_valid; a second instance runs CLK_DIV=1 loopback.
module tb_prog_bitstream_shifter;

  localparam int TB_DIV    = 2;
  localparam int TB_RST_HP = 3;
  localparam int BYTE_CYC  = 16 * TB_DIV;

  typedef struct { logic [7:0] tx; logic [7:0] rb; } item_t;
  typedef struct { logic [7:0] rb; int t; logic last; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, s_valid, s_ready, s_last, cfg_reset, m_valid;
  logic       prog_clk, prog_rst, prog_en, prog_dout, busy, done;
  logic       prog_din = 1'b0;
  logic [7:0] s_data, m_data;

  logic       f_reset, f_s_valid, f_s_ready, f_s_last, f_m_valid;
  logic       f_prog_clk, f_prog_rst, f_prog_en, f_prog_dout, f_busy, f_done;
  logic [7:0] f_s_data, f_m_data;

  prog_bitstream_shifter #(.CLK_DIV(TB_DIV), .RST_HALF_PERIODS(TB_RST_HP)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .cfg_reset(cfg_reset), .m_valid(m_valid), .m_data(m_data),
    .prog_clk(prog_clk), .prog_rst(prog_rst), .prog_en(prog_en), .prog_dout(prog_dout),
    .prog_din(prog_din), .busy(busy), .done(done)
  );

  prog_bitstream_shifter #(.CLK_DIV(1), .RST_HALF_PERIODS(2)) dut_fast (
    .clk(clk), .reset(f_reset), .s_valid(f_s_valid), .s_ready(f_s_ready), .s_data(f_s_data),
    .s_last(f_s_last), .cfg_reset(1'b0), .m_valid(f_m_valid), .m_data(f_m_data),
    .prog_clk(f_prog_clk), .prog_rst(f_prog_rst), .prog_en(f_prog_en), .prog_dout(f_prog_dout),
    .prog_din(f_prog_dout), .busy(f_busy), .done(f_done)
  );

  int tests = 0, fails = 0, cyc = 0;
  int mv_cnt = 0, done_cnt = 0, en_cycles = 0, rst_cycles = 0, k = 0;
  logic prev_clk = 1'b0, prev_dout = 1'b0;
  item_t items_q[$];
  exp_t  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Fabric model and output monitor for the main instance.
  always @(negedge clk) begin
    item_t cur;
    exp_t  e;
    if (reset) begin
      k = 0;
      prev_clk = 1'b0;
      prev_dout = 1'b0;
    end else begin
      if (prog_en) en_cycles++;
      if (prog_rst) begin
        rst_cycles++;
        check("s_ready_during_prog_rst", s_ready, 0);
      end
      if (!busy) check("idle_port_quiet", {prog_en, prog_clk, prog_rst}, 3'b000);
      else if (s_ready) check("gap_port_state", {prog_en, prog_clk}, 2'b10);
      if (prev_clk && prog_clk) check("prog_dout_stable_hi", prog_dout, prev_dout);
      if (prog_clk && !prev_clk) begin
        if (items_q.size() == 0) check("unexpected_prog_clk_rise", prog_clk, 0);
        else begin
          cur = items_q[0];
          check("prog_dout_bit", prog_dout, cur.tx[7-k]);
          k++;
          if (k == 8) begin
            k = 0;
            void'(items_q.pop_front());
          end
        end
      end
      if (m_valid) begin
        mv_cnt++;
        if (done) done_cnt++;
        if (exp_q.size() == 0) check("unexpected_m_valid", m_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e.rb);
          check("m_valid_cycle", cyc, e.t);
          check("done_with_last", done, e.last);
        end
      end else if (done) begin
        check("done_without_m_valid", done, 0);
      end
      if (items_q.size() > 0) begin
        cur = items_q[0];
        prog_din = cur.rb[7-k];
      end else begin
        prog_din = 1'b0;
      end
      prev_clk = prog_clk;
      prev_dout = prog_dout;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] rb,
                           input int delay, input logic with_cfg);
    int n = 0;
    do begin @(negedge clk); n++; end while (!s_ready && n < 500);
    check("s_ready_for_accept", s_ready, 1);
    if (!s_ready) return;
    repeat (delay) @(negedge clk);
    s_data = d; s_last = last; s_valid = 1'b1; cfg_reset = with_cfg;
    items_q.push_back('{tx: d, rb: rb});
    exp_q.push_back('{rb: rb, t: cyc + 1 + BYTE_CYC, last: last});
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; cfg_reset = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_q.size() != 0) && n < 2000);
    check("quiet_reached", {busy, exp_q.size() != 0}, 0);
  endtask

  task automatic wait_gap();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(busy && s_ready) && n < 500);
    check("gap_reached", busy && s_ready, 1);
  endtask

  // CLK_DIV=1 instance with prog_din looped back from prog_dout.
  task automatic fast_byte(input logic [7:0] d);
    int n = 0;
    do begin @(negedge clk); n++; end while (!f_s_ready && n < 100);
    check("fast_s_ready", f_s_ready, 1);
    f_s_data = d; f_s_last = 1'b1; f_s_valid = 1'b1;
    @(posedge clk); #1;
    f_s_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("fast_prog_clk_toggle", f_prog_clk, i % 2);
    end
    @(negedge clk);
    check("fast_m_valid_at_16", {f_m_valid, f_done}, 2'b11);
    check("fast_loopback_data", f_m_data, d);
  endtask

  initial begin
    int en0, mv0, d0, r0, len;
    reset = 1'b1; f_reset = 1'b1;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; cfg_reset = 1'b0;
    f_s_valid = 1'b0; f_s_data = 8'h00; f_s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {s_ready, m_valid, m_data, prog_clk, prog_rst, prog_en, prog_dout, busy, done}, 0);
    check("fast_reset_outputs", {f_s_ready, f_m_valid, f_m_data, f_prog_clk, f_prog_rst, f_prog_en,
                                 f_prog_dout, f_busy, f_done}, 0);
    @(posedge clk); #1;
    reset = 1'b0; f_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready_not_busy", {s_ready, busy}, 2'b10);

    fast_byte(8'h5A);
    for (int i = 0; i < 3; i++) fast_byte(8'($urandom));

    // Single byte 0xA5 with fabric readback 0x3C.
    en0 = en_cycles; d0 = done_cnt;
    send_byte(8'hA5, 1'b1, 8'h3C, 0, 1'b0);
    wait_quiet();
    check("single_prog_en_cycles", en_cycles - en0, BYTE_CYC);
    check("single_done_count", done_cnt - d0, 1);

    // Three-byte burst with 5-cycle gaps.
    mv0 = mv_cnt; d0 = done_cnt;
    send_byte(8'h01, 1'b0, 8'($urandom), 5, 1'b0);
    send_byte(8'hFF, 1'b0, 8'($urandom), 5, 1'b0);
    send_byte(8'h80, 1'b1, 8'($urandom), 5, 1'b0);
    wait_quiet();
    check("burst_m_valid_count", mv_cnt - mv0, 3);
    check("burst_done_count", done_cnt - d0, 1);

    // prog-reset pulse from IDLE.
    r0 = rst_cycles;
    @(posedge clk); #1 cfg_reset = 1'b1;
    @(posedge clk); #1 cfg_reset = 1'b0;
    wait_quiet();
    check("prog_rst_pulse_len", rst_cycles - r0, TB_RST_HP * TB_DIV);

    // cfg_reset while waiting in GAP is ignored.
    r0 = rst_cycles;
    send_byte(8'($urandom), 1'b0, 8'($urandom), 0, 1'b0);
    wait_gap();
    cfg_reset = 1'b1;
    repeat (4) @(negedge clk);
    cfg_reset = 1'b0;
    send_byte(8'($urandom), 1'b1, 8'($urandom), 0, 1'b0);
    wait_quiet();
    check("gap_cfg_reset_ignored", rst_cycles - r0, 0);

    // s_valid wins over cfg_reset in IDLE.
    r0 = rst_cycles; d0 = done_cnt;
    send_byte(8'($urandom), 1'b1, 8'($urandom), 0, 1'b1);
    wait_quiet();
    check("priority_no_prog_rst", rst_cycles - r0, 0);
    check("priority_byte_done", done_cnt - d0, 1);

    // Reset in the middle of 0xC3, then a clean byte.
    mv0 = mv_cnt; d0 = done_cnt;
    send_byte(8'hC3, 1'b1, 8'($urandom), 0, 1'b0);
    repeat (7 * TB_DIV) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    items_q.delete();
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", {s_ready, m_valid, m_data, prog_clk, prog_rst, prog_en, prog_dout, busy, done}, 0);
    check("reset_mid_no_m_valid", mv_cnt - mv0, 0);
    check("reset_mid_no_done", done_cnt - d0, 0);
    send_byte(8'($urandom), 1'b1, 8'($urandom), 0, 1'b0);
    wait_quiet();

    // Random bursts with random (including zero) gaps.
    for (int b = 0; b < 4; b++) begin
      len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++)
        send_byte(8'($urandom), i == len - 1, 8'($urandom), int'($urandom_range(0, 5)), 1'b0);
      wait_quiet();
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
